// File: rtl/wb_mem_arbiter_pkg.sv
// Shared types and constants for the Wishbone memory arbiter.
//  - arb_state_e  : arbiter FSM states (IDLE, GNT_I, GNT_D)
//  - data_width_e : access width carried on the bus (byte/half/word)
//  - port index constants and the default timeout error word
//  - grant_of()   : one-hot {dmem, imem} grant vector for a state
package wb_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        eDW_B = 2'd0,
        eDW_H = 2'd1,
        eDW_W = 2'd2
    } data_width_e;

    localparam int ARB_PORT_IMEM = 0;
    localparam int ARB_PORT_DMEM = 1;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    function automatic logic [1:0] grant_of(arb_state_e s);
        logic [1:0] g;
        g = 2'b00;
        if (s == GNT_I) g[ARB_PORT_IMEM] = 1'b1;
        if (s == GNT_D) g[ARB_PORT_DMEM] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// Wishbone-style bus bundle used on every arbiter port.
//  master modport: drives cyc/stb/we/addr/width/data_write, receives data_read/ack
//  slave  modport: the mirror image
interface wishbone_if;
    import wb_mem_arbiter_pkg::*;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    data_width_e width;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        ack;

    modport master (
        output cyc, stb, we, addr, width, data_write,
        input  data_read, ack
    );

    modport slave (
        input  cyc, stb, we, addr, width, data_write,
        output data_read, ack
    );
endinterface

// File: rtl/wb_mem_arbiter_mux.sv
// Combinational 2:1 request mux and ack demux keyed by the one-hot grant.
//  grant    : {dmem, imem}; 2'b00 leaves the memory bus idle
//  err_term : forced-termination cycle; memory bus dropped, granted master
//             receives ack with ERR_DATA
//  imem_wb / dmem_wb : requesting masters (slave side)
//  mem_wb            : shared memory (master side)
module wb_port_mux
    import wb_mem_arbiter_pkg::*;
#(
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic [1:0]  grant,
    input  logic        err_term,
    wishbone_if.slave   imem_wb,
    wishbone_if.slave   dmem_wb,
    wishbone_if.master  mem_wb
);
    logic sel_d;
    logic any_gnt;
    logic req_cyc;
    logic req_stb;
    logic [31:0] rdata;

    always_comb begin
        sel_d   = grant[ARB_PORT_DMEM];
        any_gnt = |grant;

        req_cyc = (grant[ARB_PORT_IMEM] & imem_wb.cyc) | (grant[ARB_PORT_DMEM] & dmem_wb.cyc);
        req_stb = (grant[ARB_PORT_IMEM] & imem_wb.stb) | (grant[ARB_PORT_DMEM] & dmem_wb.stb);

        mem_wb.cyc        = req_cyc & ~err_term;
        mem_wb.stb        = req_stb & ~err_term;
        mem_wb.we         = (sel_d ? dmem_wb.we : imem_wb.we) & any_gnt;
        mem_wb.addr       = sel_d ? dmem_wb.addr       : imem_wb.addr;
        mem_wb.width      = sel_d ? dmem_wb.width      : imem_wb.width;
        mem_wb.data_write = sel_d ? dmem_wb.data_write : imem_wb.data_write;

        // Read data is broadcast; only the acked master consumes it.
        rdata             = err_term ? ERR_DATA : mem_wb.data_read;
        imem_wb.data_read = rdata;
        dmem_wb.data_read = rdata;

        // Gating with the master's own cyc turns a same-cycle ack+abort into a
        // plain abort.
        imem_wb.ack = grant[ARB_PORT_IMEM] & imem_wb.cyc & (mem_wb.ack | err_term);
        dmem_wb.ack = grant[ARB_PORT_DMEM] & dmem_wb.cyc & (mem_wb.ack | err_term);
    end
endmodule

// File: rtl/wb_mem_arbiter.sv
// Shares one Wishbone memory slave between instruction fetch (port 0) and
// data access (port 1). One registered grant per transaction, released on
// ack, abort (master drops cyc) or timeout, followed by one idle cycle.
//  clk, rst  : clock, synchronous active-high reset
//  imem_wb   : port 0 requester
//  dmem_wb   : port 1 requester
//  mem_wb    : shared memory slave
//  oGrant    : one-hot {dmem, imem} grant, 2'b00 when idle
//  oTimeout  : high during the cycle a transaction is force-terminated
module wb_mem_arbiter
    import wb_mem_arbiter_pkg::*;
#(
    parameter bit          RR_EN    = 1'b1,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    wishbone_if.slave   imem_wb,
    wishbone_if.slave   dmem_wb,
    wishbone_if.master  mem_wb,
    output logic [1:0]  oGrant,
    output logic        oTimeout
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    arb_state_e       state_reg, state_next;
    logic             last_d_reg, last_d_next;   // 1 = DMEM served last
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [1:0] grant;
    logic       in_gnt;
    logic       owner_cyc;
    logic       err_term;
    logic       pick_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            last_d_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            last_d_reg <= last_d_next;
            cnt_reg    <= cnt_next;
        end
    end

    always_comb begin
        grant     = grant_of(state_reg);
        in_gnt    = (state_reg != IDLE);
        owner_cyc = (grant[ARB_PORT_IMEM] & imem_wb.cyc) | (grant[ARB_PORT_DMEM] & dmem_wb.cyc);
        // A real ack in the last allowed cycle still wins over the timeout.
        err_term  = (TIMEOUT != 0) && in_gnt && owner_cyc && !mem_wb.ack && (cnt_reg == CNT_LAST);
    end

    always_comb begin
        state_next  = state_reg;
        last_d_next = last_d_reg;
        cnt_next    = cnt_reg;
        pick_d      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (imem_wb.cyc || dmem_wb.cyc) begin
                    // On a tie DMEM wins unless round-robin says it went last.
                    pick_d      = dmem_wb.cyc && (!imem_wb.cyc || !RR_EN || !last_d_reg);
                    state_next  = pick_d ? GNT_D : GNT_I;
                    last_d_next = pick_d;
                    cnt_next    = '0;
                end
            end
            GNT_I, GNT_D: begin
                if (!owner_cyc || mem_wb.ack || err_term) begin
                    state_next = IDLE;
                end else if (cnt_reg != '1) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign oGrant   = grant;
    assign oTimeout = err_term;

    wb_port_mux #(
        .ERR_DATA (ERR_DATA)
    ) u_mux (
        .grant    (grant),
        .err_term (err_term),
        .imem_wb  (imem_wb),
        .dmem_wb  (dmem_wb),
        .mem_wb   (mem_wb)
    );
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Testbench for wb_mem_arbiter. Two instances share the same master stimulus:
// instance 0 round-robin, instance 1 fixed priority, both with TIMEOUT=4.
// Each has a latency-programmable memory slave and a transaction-level model
// checked every cycle; directed steps add literal expectations.
module tb_wb_mem_arbiter;
    import wb_mem_arbiter_pkg::*;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        i_cyc = 0, i_stb = 0, i_we = 0;
    logic [31:0] i_addr = 0, i_dw = 0;
    data_width_e i_width = eDW_W;
    logic        d_cyc = 0, d_stb = 0, d_we = 0;
    logic [31:0] d_addr = 0, d_dw = 0;
    data_width_e d_width = eDW_W;
    int          lat = 0;   // slave ack latency in cycles, 0 = never acks

    logic [1:0]  grant_w [2];
    logic        iack_w [2], dack_w [2], tout_w [2], mcyc_w [2], mstb_w [2], mwe_w [2], mack_w [2];
    logic [31:0] maddr_w [2], mdw_w [2], ird_w [2], drd_w [2];
    data_width_e mwidth_w [2];
    logic [15:0] gbits_w [2];
    int          gcnt_w [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        wishbone_if imem_wb ();
        wishbone_if dmem_wb ();
        wishbone_if mem_wb ();
        logic [1:0] gr;
        logic       to;

        assign imem_wb.cyc = i_cyc;  assign imem_wb.stb = i_stb;  assign imem_wb.we = i_we;
        assign imem_wb.addr = i_addr; assign imem_wb.data_write = i_dw; assign imem_wb.width = i_width;
        assign dmem_wb.cyc = d_cyc;  assign dmem_wb.stb = d_stb;  assign dmem_wb.we = d_we;
        assign dmem_wb.addr = d_addr; assign dmem_wb.data_write = d_dw; assign dmem_wb.width = d_width;

        wb_mem_arbiter #(
            .RR_EN    (gi == 0),
            .TIMEOUT  (TO),
            .ERR_DATA (ERR)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .imem_wb  (imem_wb),
            .dmem_wb  (dmem_wb),
            .mem_wb   (mem_wb),
            .oGrant   (gr),
            .oTimeout (to)
        );

        // Memory slave: acks after 'lat' cycles of continuous cyc&stb.
        int wcnt = 0;
        always @(posedge clk) begin
            if (rst) wcnt <= 0;
            else if (mem_wb.cyc && mem_wb.stb && !mem_wb.ack) wcnt <= wcnt + 1;
            else wcnt <= 0;
        end
        assign mem_wb.ack       = (lat != 0) && (wcnt == lat);
        assign mem_wb.data_read = {mem_wb.addr[15:0], 16'hC0DE};

        assign grant_w[gi] = gr;          assign tout_w[gi] = to;
        assign iack_w[gi]  = imem_wb.ack; assign dack_w[gi] = dmem_wb.ack;
        assign ird_w[gi]   = imem_wb.data_read; assign drd_w[gi] = dmem_wb.data_read;
        assign mcyc_w[gi]  = mem_wb.cyc;  assign mstb_w[gi] = mem_wb.stb; assign mwe_w[gi] = mem_wb.we;
        assign mack_w[gi]  = mem_wb.ack;  assign maddr_w[gi] = mem_wb.addr;
        assign mdw_w[gi]   = mem_wb.data_write; assign mwidth_w[gi] = mem_wb.width;

        // Grant-order recorder: bit k = 1 when the k-th grant went to DMEM.
        logic [15:0] gbits = '0;
        int          gcnt  = 0;
        logic [1:0]  gprev = 2'b00;
        always @(negedge clk) begin
            if (rst) begin
                gcnt  <= 0;
                gbits <= '0;
            end else if (gr != 2'b00 && gprev == 2'b00 && gcnt < 16) begin
                gbits[gcnt] <= gr[1];
                gcnt        <= gcnt + 1;
            end
            gprev <= gr;
        end
        assign gbits_w[gi] = gbits;
        assign gcnt_w[gi]  = gcnt;

        // Transaction model: owner (-1 none, 0 imem, 1 dmem), cycles spent in
        // the grant, and who was served last.
        int owner = -1, age = 0, last = 0;
        int n_owner = -1, n_age = 0, n_last = 0;

        always @(posedge clk) begin
            if (rst) begin
                owner <= -1; age <= 0; last <= 0;
            end else begin
                owner <= n_owner; age <= n_age; last <= n_last;
            end
        end

        always @(negedge clk) begin
            logic c, timed, acked, e_iack, e_dack, e_mcyc;
            logic [1:0]  e_grant;
            logic [31:0] o_addr, o_dw;
            logic        o_we, o_stb;
            data_width_e o_width;
            int          win;
            c       = (owner == 0) ? i_cyc : (owner == 1) ? d_cyc : 1'b0;
            acked   = (owner >= 0) && c && mack_w[gi];
            timed   = (owner >= 0) && c && !mack_w[gi] && (age == TO - 1);
            e_grant = (owner < 0) ? 2'b00 : (owner == 0) ? 2'b01 : 2'b10;
            e_iack  = (owner == 0) && (acked || timed);
            e_dack  = (owner == 1) && (acked || timed);
            e_mcyc  = (owner >= 0) && c && !timed;
            o_addr  = (owner == 1) ? d_addr : i_addr;
            o_dw    = (owner == 1) ? d_dw : i_dw;
            o_we    = (owner == 1) ? d_we : i_we;
            o_stb   = (owner == 1) ? d_stb : i_stb;
            o_width = (owner == 1) ? d_width : i_width;

            chk($sformatf("model%0d_ctrl", gi),
                {59'd0, grant_w[gi], iack_w[gi], dack_w[gi], tout_w[gi]},
                {59'd0, e_grant, e_iack, e_dack, timed});
            chk($sformatf("model%0d_mcyc", gi), mcyc_w[gi], e_mcyc);
            if (e_iack || e_dack)
                chk($sformatf("model%0d_rdata", gi), e_iack ? ird_w[gi] : drd_w[gi],
                    timed ? ERR : {o_addr[15:0], 16'hC0DE});
            if (e_mcyc)
                chk($sformatf("model%0d_req", gi),
                    {mstb_w[gi], mwe_w[gi], mwidth_w[gi], maddr_w[gi][27:0], mdw_w[gi]},
                    {o_stb, o_we, o_width, o_addr[27:0], o_dw});

            n_owner <= owner; n_age <= age; n_last <= last;
            if (owner >= 0) begin
                if (!c || acked || timed) n_owner <= -1;
                else n_age <= age + 1;
            end else begin
                win = -1;
                if (i_cyc && d_cyc) win = (gi == 0) ? 1 - last : 1;
                else if (d_cyc)     win = 1;
                else if (i_cyc)     win = 0;
                if (win >= 0) begin
                    n_owner <= win; n_age <= 0; n_last <= win;
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic dseen;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant_w[0], 2'b00);
        chk("rst_ctrl", {mcyc_w[0], mwe_w[0], iack_w[0], dack_w[0], tout_w[0]}, 5'b0);
        step; rst = 1'b0;

        // 1: IMEM only, ack on the third grant cycle
        lat = 2; i_cyc = 1; i_stb = 1; i_we = 0; i_addr = 32'h100;
        @(negedge clk);
        chk("t1_idle_first", grant_w[0], 2'b00);
        dseen = 1'b0;
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) chk("t1_grant", grant_w[0], 2'b01);
            if (dack_w[0]) dseen = 1'b1;
            if (iack_w[0]) break;
        end
        chk("t1_ack_cycle", n, 3);
        chk("t1_rdata", ird_w[0], 32'h0100C0DE);
        chk("t1_no_dack", dseen, 1'b0);
        step; i_cyc = 0; i_stb = 0;
        @(negedge clk);
        chk("t1_dead_idle", grant_w[0], 2'b00);

        // 2/3: both hold cyc; RR alternates D,I,... fixed priority starves IMEM
        step; rst = 1'b1;
        step; rst = 1'b0;
        lat = 1;
        i_cyc = 1; i_stb = 1; i_addr = 32'h104;
        d_cyc = 1; d_stb = 1; d_we = 0; d_addr = 32'h2004;
        repeat (26) @(posedge clk);
        #1; i_cyc = 0; i_stb = 0; d_cyc = 0; d_stb = 0;
        @(negedge clk);
        chk("t2_enough_grants", gcnt_w[0] >= 8, 1'b1);
        chk("t2_rr_order", gbits_w[0][7:0], 8'h55);
        chk("t3_fixed_order", gbits_w[1][7:0], 8'hFF);
        repeat (2) step;

        // 4: DMEM byte write, IMEM request held off during GNT_D
        d_cyc = 1; d_stb = 1; d_we = 1; d_addr = 32'h2000; d_dw = 32'hA5A5A5A5; d_width = eDW_B;
        step;
        i_cyc = 1; i_stb = 1; i_we = 0; i_addr = 32'h300; i_dw = 32'h11111111; i_width = eDW_W;
        @(negedge clk);
        chk("t4_grant", grant_w[0], 2'b10);
        chk("t4_req", {mwe_w[0], mwidth_w[0], maddr_w[0], mdw_w[0]}, {1'b1, eDW_B, 32'h2000, 32'hA5A5A5A5});
        chk("t4_iack_held", iack_w[0], 1'b0);
        @(negedge clk);
        chk("t4_dack", dack_w[0], 1'b1);
        step; d_cyc = 0; d_stb = 0; d_we = 0;
        @(negedge clk);
        chk("t4_dead_idle", grant_w[0], 2'b00);
        @(negedge clk);
        chk("t4_imem_next", {grant_w[0], mwe_w[0], maddr_w[0]}, {2'b01, 1'b0, 32'h300});
        @(negedge clk);
        chk("t4_iack", iack_w[0], 1'b1);
        step; i_cyc = 0; i_stb = 0;

        // 5: slave never acks -> forced termination on 4th grant cycle
        lat = 0; d_cyc = 1; d_stb = 1; d_we = 0; d_addr = 32'h2008; d_width = eDW_W;
        @(negedge clk);
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (dack_w[0]) break;
        end
        chk("t5_tmo_cycle", n, 4);
        chk("t5_err_data", drd_w[0], ERR);
        chk("t5_tmo_pulse", {tout_w[0], mcyc_w[0]}, 2'b10);
        step; d_cyc = 0; d_stb = 0;
        @(negedge clk);
        chk("t5_after", {grant_w[0], tout_w[0]}, 3'b000);

        // 6: reset while GNT_I awaits ack, then timeout counter starts fresh
        i_cyc = 1; i_stb = 1; i_addr = 32'h400;
        @(negedge clk);
        @(negedge clk);
        chk("t6_grant", grant_w[0], 2'b01);
        step; rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_rst_state", {grant_w[0], mcyc_w[0], iack_w[0]}, 4'b0000);
        step; rst = 1'b0;
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (iack_w[0]) break;
        end
        chk("t6_fresh_timeout", {n[7:0], tout_w[0]}, {8'd5, 1'b1});
        step; i_cyc = 0; i_stb = 0;

        // Abort coinciding with slave ack: no ack forwarded
        lat = 2; i_cyc = 1; i_stb = 1; i_addr = 32'h500;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        step; i_cyc = 0; i_stb = 0;
        @(negedge clk);
        chk("t7_abort_ack", {mack_w[0], mcyc_w[0], iack_w[0]}, 3'b100);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
